// File: rtl/shift_right_unit_pkg.sv
// Shared definitions for the iterative right-shift unit: default widths and FSM states.
package shift_right_unit_pkg;

    localparam int WIDTH  = 32;
    localparam int STAGES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_unit_srl_stage.sv
// One conditional right shift by 2^k with a caller-supplied fill bit.
module srl_stage #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5,
    parameter int KW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [KW-1:0]    i_k,
    input  logic             i_en,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_data
);

    logic [STAGES-1:0] w_amt;
    logic [WIDTH-1:0]  w_ones;
    logic [WIDTH-1:0]  w_mask;

    always_comb begin
        w_amt      = '0;
        w_amt[i_k] = 1'b1;
        w_ones     = '1;
        // Vacated upper bits are exactly the ones the shifted all-ones pattern no longer covers.
        w_mask     = ~(w_ones >> w_amt);
        o_data     = i_data;
        if (i_en) begin
            o_data = (i_data >> w_amt) | (w_mask & {WIDTH{i_fill}});
        end
    end

endmodule

// File: rtl/shift_right_unit.sv
// Iterative barrel shifter: one 2^k stage per cycle, registered result held until consumed.
module shift_right_unit #(
    parameter int WIDTH  = shift_right_unit_pkg::WIDTH,
    parameter int STAGES = shift_right_unit_pkg::STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [31:0]      movement,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    import shift_right_unit_pkg::*;

    localparam int CNT_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_work;
    logic [STAGES-1:0]   r_amt;
    logic                r_fill;
    logic                r_ovf;
    logic [WIDTH-1:0]    r_out;
    logic [WIDTH-1:0]    w_stage;
    logic                w_last;

    assign w_last = (r_cnt == CNT_W'(STAGES - 1));

    srl_stage #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .KW     (CNT_W)
    ) u_stage (
        .i_data (r_work),
        .i_k    (r_cnt),
        .i_en   (r_amt[r_cnt]),
        .i_fill (r_fill),
        .o_data (w_stage)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = SHIFT;
            end
            SHIFT: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_work <= '0;
            r_amt  <= '0;
            r_fill <= 1'b0;
            r_ovf  <= 1'b0;
            r_out  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work <= a;
                        r_amt  <= movement[STAGES-1:0];
                        r_fill <= arith & a[WIDTH-1];
                        r_ovf  <= |movement[31:STAGES];
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_work <= w_stage;
                    if (w_last) begin
                        r_cnt <= '0;
                        // Shift amounts of WIDTH or more push every original bit out.
                        r_out <= r_ovf ? {WIDTH{r_fill}} : w_stage;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_shift_right_unit.sv
// Directed and randomised checks of the iterative right-shift unit.
module tb_shift_right_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [31:0]   movement;
    logic          arith;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  prev_out;

    always #5 clk = ~clk;

    shift_right_unit #(.WIDTH(W), .STAGES(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .movement  (movement),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Leaves the caller at the falling edge just after the accepting edge.
    task automatic start_op(input logic [W-1:0] a_v, input logic [31:0] m_v, input logic ar_v);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a        = a_v;
        movement = m_v;
        arith    = ar_v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~a_v;
        movement = m_v ^ 32'h0000_001F;
        arith    = ~ar_v;
        chk("out_hold_shift", out, prev_out);
        chk("in_ready_shift", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_done(input string tag, input logic [W-1:0] exp);
        int lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd5);
        chk({tag, "_out"}, out, exp);
    endtask

    task automatic release_op(input logic [W-1:0] exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_release", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);
        chk("out_retained_idle", out, exp);
        prev_out = exp;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a_v, input logic [31:0] m_v,
                          input logic ar_v, input logic [W-1:0] exp);
        start_op(a_v, m_v, ar_v);
        wait_done(tag, exp);
        release_op(exp);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rexp;
        logic [31:0]  rm;
        logic         rar;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        movement  = '0;
        arith     = 1'b0;
        out_ready = 1'b0;
        prev_out  = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out", out, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("logical_4",      32'hF000_0000, 32'd4,  1'b0, 32'h0F00_0000);
        run_op("arith_31",       32'h8000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF);
        run_op("logical_31",     32'h8000_0000, 32'd31, 1'b0, 32'h0000_0001);
        run_op("ovf_arith",      32'h8765_4321, 32'h20, 1'b1, 32'hFFFF_FFFF);
        run_op("ovf_logical",    32'h8765_4321, 32'h20, 1'b0, 32'h0000_0000);
        run_op("zero_shift",     32'h8765_4321, 32'd0,  1'b1, 32'h8765_4321);
        run_op("ovf_high_bit",   32'h7FFF_FFFF, 32'h8000_0003, 1'b1, 32'h0000_0000);
        run_op("arith_pos_16",   32'h7654_3210, 32'd16, 1'b1, 32'h0000_7654);
        run_op("arith_neg_3",    32'hCAFE_F00D, 32'd3,  1'b1, 32'hF95F_DE01);

        // Consumer stall with a competing request that must be ignored.
        start_op(32'h1234_5678, 32'd8, 1'b0);
        wait_done("stall", 32'h0012_3456);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                a        = 32'hDEAD_BEEF;
                movement = 32'd1;
                arith    = 1'b1;
            end
            if (i == 7) in_valid = 1'b0;
            @(negedge clk);
            chk("stall_out_stable", out, 32'h0012_3456);
            chk("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        release_op(32'h0012_3456);
        repeat (8) @(negedge clk);
        chk("stall_req_ignored", {31'd0, out_valid}, 32'd0);
        chk("stall_out_kept", out, 32'h0012_3456);

        // Reset in the third SHIFT cycle aborts the operation.
        start_op(32'hCAFE_F00D, 32'd3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out", out, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        prev_out = '0;
        repeat (8) @(negedge clk);
        chk("abort_no_result", {31'd0, out_valid}, 32'd0);
        run_op("after_abort", 32'h1234_5678, 32'd8, 1'b0, 32'h0012_3456);

        for (int n = 0; n < 12; n++) begin
            ra  = $urandom;
            rm  = $urandom_range(0, 40);
            rar = 1'($urandom_range(0, 1));
            if (rar) rexp = $signed(ra) >>> rm;
            else     rexp = ra >> rm;
            run_op("random", ra, rm, rar, rexp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_right_unit.md
SHIFT_RIGHT_UNIT -- requirements
Module: shift_right_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width.
REQ-002 Parameter: STAGES, default 5, number of shift stages; 2^STAGES = WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present on a, movement, arith.
REQ-006 in_ready  output  1  unit accepts a request this cycle.
REQ-007 a  input  WIDTH  operand to shift right.
REQ-008 movement  input  32  shift amount, unsigned.
REQ-009 arith  input  1  1 = arithmetic (sign fill); 0 = logical (zero fill).
REQ-010 out_valid  output  1  result on out is valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 out  output  WIDTH  shifted result, registered.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 An in_valid&&in_ready edge SHALL capture a, movement[4:0], arith and the overflow flag (|movement[31:5]), clear the stage counter, and enter SHIFT.
REQ-016 In SHIFT, each cycle SHALL process one stage k (k = 0..4, ascending): when the captured movement[k] is 1, the working value shifts right by 2^k with the fill bit.
REQ-017 The fill bit SHALL be arith ? a[WIDTH-1] : 0, as captured at acceptance.
REQ-018 After stage 4 completes, the FSM SHALL enter DONE; out_valid SHALL be first high 5 cycles after the accepting edge.
REQ-019 When the overflow flag is set, the result SHALL be all fill bits (0 for logical; {WIDTH{a[WIDTH-1]}} for arithmetic), independent of movement[4:0].
REQ-020 movement == 0 SHALL return a unchanged, still with 5-cycle latency.
REQ-021 In DONE, out SHALL hold stable until out_ready is 1; out_valid&&out_ready SHALL return the FSM to IDLE.
REQ-022 No request SHALL be accepted in the cycle DONE exits; the minimum request spacing is 7 cycles.
REQ-023 Input changes while in SHIFT or DONE SHALL have no effect.
REQ-024 out SHALL update only on entry to DONE; out SHALL retain its last value while in IDLE and SHIFT.

Reset
REQ-025 rst SHALL force IDLE and clear the stage counter; out and out_valid SHALL be 0, and in_ready SHALL be 1 from the next cycle.
REQ-026 rst asserted during SHIFT or DONE SHALL abort the operation with no result delivered.
REQ-027 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-028 A shared package SHALL define the state enum (IDLE, SHIFT, DONE), WIDTH and STAGES.
REQ-029 A single sub-module, srl_stage, SHALL implement one conditional right shift by 2^k with a fill input.
REQ-030 srl_stage SHALL be reused across stages by selecting k with the stage counter.
REQ-031 The datapath SHALL contain no combinational path from the inputs to out.

Verification
REQ-032 a=0xF000_0000, movement=4, arith=0 -> out=0x0F00_0000, out_valid high 5 cycles after acceptance.
REQ-033 a=0x8000_0000, movement=31, arith=1 -> out=0xFFFF_FFFF; same input with arith=0 -> out=0x0000_0001.
REQ-034 a=0x8765_4321, movement=0x20 -> out=0xFFFF_FFFF for arith=1 and out=0 for arith=0; movement=0 -> out=0x8765_4321.
REQ-035 A result with out_ready held low for 10 cycles -> out stable and in_ready low throughout; a new in_valid in that window is ignored.
REQ-036 rst pulsed during the third SHIFT cycle -> next cycle out_valid=0, out=0, in_ready=1; a following request completes correctly.
REQ-037 A random sweep of a, movement in 0..40 and arith, compared with a reference >> / >>> model -> no mismatches.
